verinject_memn_injector: RTL and testbench

- Next-generation memory fault injector for a single memory array.
- Captures bit-flip injections addressed by the global injector state into a parametrised fault store.
- Applies all stored flips to N independent read ports.
- Retires a stored fault when its memory word is rewritten.
- Adds over the prior generation: reset, valid bits instead of sentinel values, defined overflow policy, multi-port reads and status outputs.
- Sits between a memory array's read-data path and its consumers; the write port is observed only.

---
 rtl/verinject_pkg.sv | 21 ++
 rtl/verinject_mem_fault_mask.sv | 47 ++++
 rtl/verinject_memn_injector.sv | 134 +++++++++++++
 tb/tb_verinject_memn_injector.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/verinject_pkg.sv
// Shared constants and index-arithmetic helpers for the memory fault injector.
package verinject_pkg;

   localparam int VERINJECT_STATE_W = 32;

   function automatic logic [31:0] word_len_f(input int l, input int r);
      return (l > r) ? 32'(l - r + 1) : 32'(r - l + 1);
   endfunction

   function automatic logic [31:0] range_start_f(input int a, input int b);
      return (a < b) ? 32'(a) : 32'(b);
   endfunction

   // Unsigned subtraction cannot wrap because the lower bound is checked first.
   function automatic logic in_word_f(input logic [31:0] idx,
                                      input logic [31:0] word_start,
                                      input logic [31:0] word_len);
      return (idx >= word_start) && ((idx - word_start) < word_len);
   endfunction

endpackage

// File: rtl/verinject_mem_fault_mask.sv
// Builds the XOR flip mask for one read address from the stored faults plus the
// live injector state.
module verinject_mem_fault_mask
   import verinject_pkg::*;
#(
   parameter int  LEFT       = 0,
   parameter int  RIGHT      = 0,
   parameter int  ADDR_LEFT  = 0,
   parameter int  ADDR_RIGHT = 0,
   parameter int  MEM_LEFT   = 0,
   parameter int  MEM_RIGHT  = 0,
   parameter int  P_START    = 0,
   parameter int  FIFO_DEPTH = 4,
   localparam int WL         = int'(word_len_f(LEFT, RIGHT)),
   localparam int ADDR_W     = int'(word_len_f(ADDR_LEFT, ADDR_RIGHT))
) (
   input  logic [FIFO_DEPTH-1:0][VERINJECT_STATE_W-1:0] slots,
   input  logic [FIFO_DEPTH-1:0]                        valid,
   input  logic [VERINJECT_STATE_W-1:0]                 live_state,
   input  logic [ADDR_W-1:0]                            address,
   output logic [WL-1:0]                                mask
);

   localparam logic [31:0] WORD_LEN  = word_len_f(LEFT, RIGHT);
   localparam logic [31:0] MEM_START = range_start_f(MEM_LEFT, MEM_RIGHT);
   localparam logic [31:0] MEM_LEN   = word_len_f(MEM_LEFT, MEM_RIGHT);

   logic [31:0] addr32;
   logic [31:0] word_start;
   logic        addr_ok;

   always_comb begin
      addr32     = 32'(address);
      addr_ok    = in_word_f(addr32, MEM_START, MEM_LEN);
      word_start = 32'(P_START) + (addr32 - MEM_START) * WORD_LEN;
      mask       = '0;
      if (addr_ok) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid[i] && in_word_f(slots[i], word_start, WORD_LEN))
               mask ^= WL'(1) << (slots[i] - word_start);
         end
         if (in_word_f(live_state, word_start, WORD_LEN))
            mask ^= WL'(1) << (live_state - word_start);
      end
   end

endmodule

// File: rtl/verinject_memn_injector.sv
// Fault store for one memory array: captures injected bit flips, retires them on
// rewrite of their word, and applies them to every read port.
module verinject_memn_injector
   import verinject_pkg::*;
#(
   parameter int  LEFT       = 0,
   parameter int  RIGHT      = 0,
   parameter int  ADDR_LEFT  = 0,
   parameter int  ADDR_RIGHT = 0,
   parameter int  MEM_LEFT   = 0,
   parameter int  MEM_RIGHT  = 0,
   parameter int  P_START    = 0,
   parameter int  FIFO_DEPTH = 4,
   parameter int  READ_PORTS = 1,
   localparam int WL         = int'(word_len_f(LEFT, RIGHT)),
   localparam int ADDR_W     = int'(word_len_f(ADDR_LEFT, ADDR_RIGHT)),
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [VERINJECT_STATE_W-1:0]   verinject__injector_state,
   input  logic [READ_PORTS*WL-1:0]       unmodified,
   input  logic [READ_PORTS*ADDR_W-1:0]   read_address,
   output logic [READ_PORTS*WL-1:0]       modified,
   input  logic                           do_write,
   input  logic [ADDR_W-1:0]              write_address,
   output logic [CNT_W-1:0]               active_count,
   output logic                           overflow
);

   localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [31:0] WORD_LEN  = word_len_f(LEFT, RIGHT);
   localparam logic [31:0] MEM_START = range_start_f(MEM_LEFT, MEM_RIGHT);
   localparam logic [31:0] MEM_LEN   = word_len_f(MEM_LEFT, MEM_RIGHT);
   localparam logic [31:0] TOTAL     = MEM_LEN * WORD_LEN;

   logic [FIFO_DEPTH-1:0][VERINJECT_STATE_W-1:0] slots_q, slots_n;
   logic [FIFO_DEPTH-1:0]                        valid_q, valid_n;
   logic [PTR_W-1:0]                             ptr_q, ptr_n;
   logic                                         overflow_n;
   logic [CNT_W-1:0]                             count_n;
   logic                                         capture;
   logic                                         waddr_ok;
   logic [31:0]                                  waddr32;
   logic [31:0]                                  wword_start;
   logic                                         free_found;
   logic [PTR_W-1:0]                             free_idx;

   // Erase is evaluated on the old slots before the capture lands, so a fault
   // injected into the word being written survives and may reuse a freed slot.
   always_comb begin
      slots_n     = slots_q;
      valid_n     = valid_q;
      ptr_n       = ptr_q;
      overflow_n  = overflow;
      free_found  = 1'b0;
      free_idx    = '0;
      count_n     = '0;
      capture     = in_word_f(verinject__injector_state, 32'(P_START), TOTAL);
      waddr32     = 32'(write_address);
      waddr_ok    = in_word_f(waddr32, MEM_START, MEM_LEN);
      wword_start = 32'(P_START) + (waddr32 - MEM_START) * WORD_LEN;

      if (do_write && waddr_ok) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid_q[i] && in_word_f(slots_q[i], wword_start, WORD_LEN))
               valid_n[i] = 1'b0;
         end
      end

      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (!valid_n[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = PTR_W'(i);
         end
      end

      if (capture) begin
         if (free_found) begin
            slots_n[free_idx] = verinject__injector_state;
            valid_n[free_idx] = 1'b1;
         end else begin
            slots_n[ptr_q] = verinject__injector_state;
            ptr_n          = (ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
            overflow_n     = 1'b1;
         end
      end

      for (int i = 0; i < FIFO_DEPTH; i++)
         count_n = count_n + CNT_W'(valid_n[i]);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slots_q      <= '0;
         valid_q      <= '0;
         ptr_q        <= '0;
         overflow     <= 1'b0;
         active_count <= '0;
      end else begin
         slots_q      <= slots_n;
         valid_q      <= valid_n;
         ptr_q        <= ptr_n;
         overflow     <= overflow_n;
         active_count <= count_n;
      end
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
      logic [WL-1:0] mask;

      verinject_mem_fault_mask #(
         .LEFT       (LEFT),
         .RIGHT      (RIGHT),
         .ADDR_LEFT  (ADDR_LEFT),
         .ADDR_RIGHT (ADDR_RIGHT),
         .MEM_LEFT   (MEM_LEFT),
         .MEM_RIGHT  (MEM_RIGHT),
         .P_START    (P_START),
         .FIFO_DEPTH (FIFO_DEPTH)
      ) u_mask (
         .slots      (slots_q),
         .valid      (valid_q),
         .live_state (verinject__injector_state),
         .address    (read_address[p*ADDR_W +: ADDR_W]),
         .mask       (mask)
      );

      // Reset hides the live state too, so reads pass through untouched.
      assign modified[p*WL +: WL] = reset ? unmodified[p*WL +: WL]
                                          : unmodified[p*WL +: WL] ^ mask;
   end

endmodule

// File: tb/tb_verinject_memn_injector.sv
// Directed and randomized checks of the fault injector against a behavioural
// fault-list model (8-bit words, 16 words, P_START=100, 4 slots, 2 ports).
module tb_verinject_memn_injector;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;
   localparam int          PS   = 100;
   localparam int          NW   = 16;
   localparam int          WLEN = 8;
   localparam int          DEP  = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] inj;
   logic [15:0] unmod;
   logic [7:0]  raddr;
   logic [15:0] modified;
   logic        we;
   logic [3:0]  waddr;
   logic [2:0]  active_count;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   int unsigned m_idx [DEP];
   bit          m_val [DEP];
   int          m_ptr;
   bit          m_ovf;

   always #5 clock = ~clock;

   verinject_memn_injector #(
      .LEFT       (7),
      .RIGHT      (0),
      .ADDR_LEFT  (3),
      .ADDR_RIGHT (0),
      .MEM_LEFT   (0),
      .MEM_RIGHT  (15),
      .P_START    (PS),
      .FIFO_DEPTH (DEP),
      .READ_PORTS (2)
   ) dut (
      .clock                     (clock),
      .reset                     (reset),
      .verinject__injector_state (inj),
      .unmodified                (unmod),
      .read_address              (raddr),
      .modified                  (modified),
      .do_write                  (we),
      .write_address             (waddr),
      .active_count              (active_count),
      .overflow                  (overflow)
   );

   function automatic bit in_mem(int unsigned idx);
      return idx >= PS && idx < PS + NW * WLEN;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < DEP; i++) begin
         m_idx[i] = 0;
         m_val[i] = 0;
      end
      m_ptr = 0;
      m_ovf = 0;
   endfunction

   // Fault list semantics: erase by word first, then place in lowest free slot
   // or replace round-robin on a full list.
   function automatic void model_update(int unsigned st, bit w, int wa);
      int fr;
      if (w)
         for (int i = 0; i < DEP; i++)
            if (m_val[i] && (m_idx[i] - PS) / WLEN == wa) m_val[i] = 0;
      if (in_mem(st)) begin
         fr = -1;
         for (int i = 0; i < DEP; i++)
            if (!m_val[i] && fr < 0) fr = i;
         if (fr >= 0) begin
            m_idx[fr] = st;
            m_val[fr] = 1;
         end else begin
            m_idx[m_ptr] = st;
            m_ptr = (m_ptr + 1) % DEP;
            m_ovf = 1;
         end
      end
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < DEP; i++) c += int'(m_val[i]);
      return c;
   endfunction

   function automatic logic [7:0] exp_read(int addr, logic [7:0] data, int unsigned live);
      logic [7:0] m = 8'h00;
      for (int i = 0; i < DEP; i++)
         if (m_val[i] && (m_idx[i] - PS) / WLEN == addr)
            m ^= 8'(1 << ((m_idx[i] - PS) % WLEN));
      if (in_mem(live) && (live - PS) / WLEN == addr)
         m ^= 8'(1 << ((live - PS) % WLEN));
      return data ^ m;
   endfunction

   task automatic tick();
      @(posedge clock);
      model_update(inj, we, int'(waddr));
      #1;
   endtask

   task automatic apply_reset();
      inj   = IDLE;
      we    = 1'b0;
      reset = 1'b1;
      #2;
      model_reset();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      inj   = 32'd113;
      we    = 1'b0;
      waddr = 4'd0;
      raddr = {4'd1, 4'd1};
      unmod = 16'h3C5A;
      model_reset();
      #12;
      checks++;
      if (active_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0", active_count);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_overflow got %0b want 0", overflow);
      end
      checks++;
      if (modified !== 16'h3C5A) begin
         errors++;
         $display("FAIL reset_passthrough got %h want 3c5a", modified);
      end
      reset = 1'b0;
      inj   = IDLE;
      tick();
   endtask

   task automatic test_single_inject();
      logic [7:0] d1;
      d1    = 8'($urandom);
      inj   = 32'd113;  // word 1, bit 5
      raddr = {4'd2, 4'd1};
      unmod = {d1, 8'h00};
      #1;
      checks++;
      if (modified !== {d1, 8'h20}) begin
         errors++;
         $display("FAIL inject_live got %h want %h", modified, {d1, 8'h20});
      end
      tick();
      inj = IDLE;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (modified !== {d1, 8'h20} || active_count !== 3'd1) begin
            errors++;
            $display("FAIL inject_persist cyc %0d got %h/%0d want %h/1",
                     c, modified, active_count, {d1, 8'h20});
         end
         tick();
      end
   endtask

   task automatic test_erase();
      we    = 1'b1;
      waddr = 4'd1;
      raddr = {4'd1, 4'd1};
      unmod = 16'h0000;
      tick();
      we = 1'b0;
      #1;
      checks++;
      if (modified !== 16'h0000 || active_count !== 3'd0) begin
         errors++;
         $display("FAIL erase got %h/%0d want 0000/0", modified, active_count);
      end
   endtask

   task automatic test_simultaneous();
      inj   = 32'd108;
      we    = 1'b1;
      waddr = 4'd1;
      raddr = {4'd0, 4'd1};
      unmod = 16'h0000;
      #1;
      checks++;
      if (modified !== 16'h0001) begin
         errors++;
         $display("FAIL simul_live got %h want 0001", modified);
      end
      tick();
      inj = IDLE;
      we  = 1'b0;
      #1;
      checks++;
      if (modified !== 16'h0001 || active_count !== 3'd1) begin
         errors++;
         $display("FAIL simul_store got %h/%0d want 0001/1", modified, active_count);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] seq [4];
      apply_reset();
      seq = '{32'd100, 32'd108, 32'd116, 32'd124};
      foreach (seq[i]) begin
         inj = seq[i];
         tick();
      end
      inj = IDLE;
      #1;
      checks++;
      if (active_count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_full got %0d/%0b want 4/0", active_count, overflow);
      end
      inj = 32'd132;
      tick();
      inj   = IDLE;
      raddr = {4'd4, 4'd0};
      unmod = 16'h0000;
      #1;
      checks++;
      if (modified !== 16'h0100 || active_count !== 3'd4 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_evict0 got %h/%0d/%0b want 0100/4/1",
                  modified, active_count, overflow);
      end
      inj = 32'd140;
      tick();
      inj   = IDLE;
      raddr = {4'd5, 4'd1};
      #1;
      checks++;
      if (modified !== 16'h0100) begin
         errors++;
         $display("FAIL ovf_evict1 got %h want 0100", modified);
      end
      raddr = {4'd3, 4'd2};
      #1;
      checks++;
      if (modified !== 16'h0101 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_survivors got %h/%0b want 0101/1", modified, overflow);
      end
   endtask

   task automatic test_cancel();
      logic [7:0] d;
      apply_reset();
      d     = 8'($urandom);
      raddr = {4'd1, 4'd1};
      unmod = {d, d};
      inj   = 32'd113;
      tick();
      #1;
      checks++;
      if (modified !== {d, d}) begin
         errors++;
         $display("FAIL cancel_live got %h want %h", modified, {d, d});
      end
      tick();
      inj = IDLE;
      #1;
      checks++;
      if (modified !== {d, d} || active_count !== 3'd2) begin
         errors++;
         $display("FAIL cancel_store got %h/%0d want %h/2", modified, active_count, {d, d});
      end
   endtask

   task automatic test_async_reset();
      inj = 32'd150;
      tick();
      inj = IDLE;
      #1;
      checks++;
      if (active_count !== 3'd3) begin
         errors++;
         $display("FAIL areset_pre got %0d want 3", active_count);
      end
      inj   = 32'd150;
      raddr = {4'd6, 4'd1};
      unmod = 16'($urandom);
      reset = 1'b1;
      #1;
      checks++;
      if (active_count !== 3'd0 || overflow !== 1'b0 || modified !== unmod) begin
         errors++;
         $display("FAIL areset_now got %0d/%0b/%h want 0/0/%h",
                  active_count, overflow, modified, unmod);
      end
      model_reset();
      reset = 1'b0;
      inj   = IDLE;
      tick();
   endtask

   task automatic test_random();
      int          sel;
      logic [7:0]  e0, e1;
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 5)       inj = 32'(PS + $urandom_range(0, NW * WLEN - 1));
         else if (sel == 5) inj = 32'($urandom_range(0, PS - 1));
         else if (sel == 6) inj = 32'(PS + NW * WLEN + $urandom_range(0, 999));
         else               inj = IDLE;
         we    = ($urandom_range(0, 3) == 0);
         waddr = 4'($urandom);
         raddr = 8'($urandom);
         unmod = 16'($urandom);
         #1;
         e0 = exp_read(int'(raddr[3:0]), unmod[7:0], inj);
         e1 = exp_read(int'(raddr[7:4]), unmod[15:8], inj);
         checks++;
         if (modified !== {e1, e0}) begin
            errors++;
            $display("FAIL rand_read n=%0d got %h want %h", n, modified, {e1, e0});
         end
         tick();
         checks++;
         if (active_count !== 3'(model_count()) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand_status n=%0d got %0d/%0b want %0d/%0b",
                     n, active_count, overflow, model_count(), m_ovf);
         end
      end
      inj = IDLE;
      we  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_inject();
      test_erase();
      test_simultaneous();
      test_overflow();
      test_cancel();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
